// File: rtl/debug_vjtag_scan_master.sv
// debug_vjtag_scan_master
//   Host side of the virtual-JTAG debug-slave protocol. Each accepted command
//   performs one virtual IR load (UIR) followed by one DR scan
//   (CDR -> SDR x DR_WIDTH -> UDR). The bits captured from tdo are then
//   returned on the response channel. tck is a divided strobe generated from
//   clk: low for TCK_DIV cycles, then high for TCK_DIV cycles.
//
// Optional feature (macro DEBUG_VJTAG_IR_CACHE_EN):
//   When defined, the last loaded IR is remembered. A command whose IR equals
//   it skips the UIR state. The first command after reset always loads the IR.
//
// Ports
//   clk, reset             system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_ir and cmd_data are latched on accept
//   rsp_valid/rsp_ready    response handshake; rsp_data[0] holds the first tdo bit
//   tck, tdi, tdo          generated test clock, serial data out, serial data in
//   ir_in                  virtual IR presented to the slave
//   vs_uir/cdr/sdr/udr     virtual state strobes, one-hot while a scan runs
//   jtag_state_rti         high while the master is idle
module debug_vjtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int DIV_W = (TCK_DIV <= 1) ? 1 : $clog2(2 * TCK_DIV);
  localparam int BIT_W = $clog2(DR_WIDTH + 1);
  // Divider positions within one tck period.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RSP
  } state_t;

  state_t state_reg, state_next;

  logic [DIV_W-1:0]    div_reg;
  logic [DIV_W-1:0]    div_inc;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [DR_WIDTH-1:0] shift_nxt;
  logic [DR_WIDTH-1:0] capture_reg;
  logic [BIT_W-1:0]    bit_idx_reg;
  logic                active;
  logic                period_end;
  logic                rise_edge;
  logic                last_bit;
  logic                skip_uir;

  assign active     = (state_reg == ST_UIR) || (state_reg == ST_CDR) ||
                      (state_reg == ST_SDR) || (state_reg == ST_UDR);
  // The state machine moves only at the end of a high phase (tck falling).
  assign period_end = active && (div_reg == DIV_LAST);
  // The clk edge that drives tck high is the tdo sampling edge.
  assign rise_edge  = active && (div_reg == DIV_RISE);
  assign last_bit   = (bit_idx_reg == BIT_LAST);
  assign div_inc    = div_reg + DIV_W'(1);
  assign shift_nxt  = shift_reg >> 1;

`ifdef DEBUG_VJTAG_IR_CACHE_EN
  logic [IR_WIDTH-1:0] last_ir_reg;
  logic                ir_known_reg;

  // ir_known_reg forces a real IR load for the first command after reset,
  // even when that command's IR matches the reset value of last_ir_reg.
  assign skip_uir = ir_known_reg && (cmd_ir == last_ir_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ir_reg  <= '0;
      ir_known_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && cmd_valid) begin
      last_ir_reg  <= cmd_ir;
      ir_known_reg <= 1'b1;
    end
  end
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready      = 1'b0;
    jtag_state_rti = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
        if (cmd_valid) state_next = skip_uir ? ST_CDR : ST_UIR;
      end
      ST_UIR: begin
        vs_uir = 1'b1;
        if (period_end) state_next = ST_CDR;
      end
      ST_CDR: begin
        vs_cdr = 1'b1;
        if (period_end) state_next = ST_SDR;
      end
      ST_SDR: begin
        vs_sdr = 1'b1;
        if (period_end && last_bit) state_next = ST_UDR;
      end
      ST_UDR: begin
        vs_udr = 1'b1;
        if (period_end) state_next = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg     <= '0;
      tck         <= 1'b0;
      tdi         <= 1'b0;
      ir_in       <= '0;
      shift_reg   <= '0;
      capture_reg <= '0;
      bit_idx_reg <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            div_reg     <= '0;
            tck         <= 1'b0;
            tdi         <= 1'b0;
            // With the IR cache a skipped load implies cmd_ir already equals ir_in.
            ir_in       <= cmd_ir;
            shift_reg   <= cmd_data;
            capture_reg <= '0;
            bit_idx_reg <= '0;
          end
        end
        ST_RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
          // Running divider shared by UIR/CDR/SDR/UDR.
          if (period_end) begin
            div_reg <= '0;
            tck     <= 1'b0;
          end else begin
            div_reg <= div_inc;
            tck     <= (div_inc >= DIV_HIGH);
          end

          if (rise_edge && state_reg == ST_SDR) capture_reg[bit_idx_reg] <= tdo;

          if (period_end) begin
            case (state_reg)
              ST_UIR: tdi <= 1'b0;
              // Leaving CDR: present the first data bit for the first SDR period.
              ST_CDR: tdi <= shift_reg[0];
              ST_SDR: begin
                shift_reg   <= shift_nxt;
                bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                tdi         <= last_bit ? 1'b0 : shift_nxt[0];
              end
              ST_UDR: begin
                rsp_data  <= capture_reg;
                rsp_valid <= 1'b1;
              end
              default: tdi <= 1'b0;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_vjtag_scan_master.sv
module tb_debug_vjtag_scan_master;

  localparam int DRW = 38;
  localparam int IRW = 2;
  localparam int TD  = 2;
  localparam int LAT_FULL = 2 * TD * (DRW + 3);
`ifdef DEBUG_VJTAG_IR_CACHE_EN
  localparam int LAT_CACHED = 2 * TD * (DRW + 2);
  localparam int UIR_CACHED = 0;
`else
  localparam int LAT_CACHED = 2 * TD * (DRW + 3);
  localparam int UIR_CACHED = 2 * TD;
`endif

  logic            clk;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IRW-1:0]  cmd_ir;
  logic [DRW-1:0]  cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DRW-1:0]  rsp_data;
  logic            tck;
  logic            tdi;
  logic            tdo;
  logic [IRW-1:0]  ir_in;
  logic            vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic            jtag_state_rti;

  debug_vjtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave shift-register model: shifts tdi in at each tck rise while in SDR.
  logic [DRW-1:0] slave_sr = '0;
  logic [DRW-1:0] preload_val = '0;
  logic           preload_en = 1'b0;
  logic           tck_d = 1'b0;
  int             tdo_mode = 0;   // 0 model, 1 stuck high, 2 stuck low

  assign tdo = (tdo_mode == 1) ? 1'b1 : (tdo_mode == 2) ? 1'b0 : slave_sr[0];

  always @(posedge clk) begin
    tck_d <= tck;
    if (preload_en) slave_sr <= preload_val;
    else if (tck && !tck_d && vs_sdr) slave_sr <= {tdi, slave_sr[DRW-1:1]};
  end

  // Strobe monitor: cycle counts per state plus protocol error counters.
  int uir_c = 0, cdr_c = 0, sdr_c = 0, udr_c = 0, sdr_rises = 0;
  int proto_err = 0;
  int last_idx = 0;
  logic tck_prev = 1'b0;
  logic [IRW-1:0] mon_ir = '0;

  always @(negedge clk) begin
    int idx;
    idx = 0;
    if (!reset) begin
      if (vs_uir) begin uir_c++; idx = 1; end
      if (vs_cdr) begin cdr_c++; idx = 2; end
      if (vs_sdr) begin sdr_c++; idx = 3; end
      if (vs_udr) begin udr_c++; idx = 4; end
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr}) > 1) proto_err++;
      if (idx != 0) begin
        if (idx < last_idx) proto_err++;
        last_idx = idx;
        if (idx >= 2 && ir_in !== mon_ir) proto_err++;
      end else begin
        last_idx = 0;
      end
      if (vs_sdr && tck && !tck_prev) sdr_rises++;
      if ((cmd_ready || rsp_valid) && (tck || idx != 0)) proto_err++;
    end
    tck_prev = tck;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tck"}, {63'd0, tck}, 64'd0);
    chk({tag, "_tdi"}, {63'd0, tdi}, 64'd0);
    chk({tag, "_ir_in"}, {62'd0, ir_in}, 64'd0);
    chk({tag, "_vs"}, {60'd0, vs_uir, vs_cdr, vs_sdr, vs_udr}, 64'd0);
    chk({tag, "_rti"}, {63'd0, jtag_state_rti}, 64'd1);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_data"}, {26'd0, rsp_data}, 64'd0);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic load_slave(input logic [DRW-1:0] val);
    preload_val = val;
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  // Issues one command at an edge where the DUT is idle; returns the number of
  // clk edges from the accepting edge to the one that raises rsp_valid.
  task automatic issue_and_wait(input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                                output int lat);
    mon_ir    = ir;
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
  endtask

  task automatic do_scan(input string tag, input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                         input logic [DRW-1:0] pre, input int mode, input logic [DRW-1:0] exp_rsp,
                         input int exp_lat, input int exp_uir);
    int lat;
    int s_uir, s_cdr, s_sdr, s_udr, s_rise, s_err;
    logic [DRW-1:0] got;
    tdo_mode = mode;
    load_slave(pre);
    s_uir = uir_c; s_cdr = cdr_c; s_sdr = sdr_c; s_udr = udr_c;
    s_rise = sdr_rises; s_err = proto_err;
    rsp_ready = 1'b1;
    issue_and_wait(ir, data, lat);
    got = rsp_data;
    @(posedge clk); #1;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rsp_data"}, {26'd0, got}, {26'd0, exp_rsp});
    chk({tag, "_rsp_cleared"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_ir_in"}, {62'd0, ir_in}, {62'd0, ir});
    chk({tag, "_uir_cycles"}, 64'(uir_c - s_uir), 64'(exp_uir));
    chk({tag, "_cdr_cycles"}, 64'(cdr_c - s_cdr), 64'(2 * TD));
    chk({tag, "_sdr_cycles"}, 64'(sdr_c - s_sdr), 64'(2 * TD * DRW));
    chk({tag, "_udr_cycles"}, 64'(udr_c - s_udr), 64'(2 * TD));
    chk({tag, "_sdr_tck_rises"}, 64'(sdr_rises - s_rise), 64'(DRW));
    chk({tag, "_protocol"}, 64'(proto_err - s_err), 64'd0);
    if (mode == 0) chk({tag, "_slave_holds_cmd"}, {26'd0, slave_sr}, {26'd0, data});
    $display("scan %s: ir=%0b data=%h rsp=%h latency=%0d", tag, ir, data, got, lat);
  endtask

  typedef struct {
    string          name;
    logic [IRW-1:0] ir;
    logic [DRW-1:0] data;
    logic [DRW-1:0] preload;
    int             mode;
    logic [DRW-1:0] exp_rsp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat;
    int bad;
    int rsp_seen;
    logic [DRW-1:0] held;

    vecs[0] = '{"loop_a",  2'b01, 38'h2A_5555_AAAA, 38'h3F_0000_FFFF, 0, 38'h3F_0000_FFFF};
    vecs[1] = '{"loop_b",  2'b10, 38'h00_0000_0000, 38'h15_1234_5678, 0, 38'h15_1234_5678};
    vecs[2] = '{"stuck_1", 2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 1, 38'h3F_FFFF_FFFF};
    vecs[3] = '{"stuck_0", 2'b00, 38'h12_3456_789A, 38'h3F_FFFF_FFFF, 2, 38'h00_0000_0000};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;
    $display("reset: power-on values checked");

    for (int i = 0; i < 4; i++)
      do_scan(vecs[i].name, vecs[i].ir, vecs[i].data, vecs[i].preload, vecs[i].mode,
              vecs[i].exp_rsp, LAT_FULL, 2 * TD);

    // Response back-pressure: result must stay put while rsp_ready is low.
    tdo_mode = 0;
    load_slave(38'h01_8421_C3A5);
    rsp_ready = 1'b0;
    issue_and_wait(2'b01, 38'h0F_F00F_F00F, lat);
    chk("stall_latency", 64'(lat), 64'(LAT_FULL));
    chk("stall_rsp_data", {26'd0, rsp_data}, {26'd0, 38'h01_8421_C3A5});
    held = rsp_data;
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", {63'd0, rsp_valid}, 64'd0);
    chk("stall_release_ready", {63'd0, cmd_ready}, 64'd1);
    $display("stall: rsp held 50 cycles, rsp=%h", held);

    // Reset in the middle of the data scan aborts it.
    load_slave(38'h2B_CDEF_0123);
    mon_ir = 2'b11;
    cmd_ir = 2'b11; cmd_data = 38'h11_2233_4455; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("midreset_in_sdr", {63'd0, vs_sdr}, 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_seen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    chk("midreset_no_rsp", 64'(rsp_seen), 64'd0);
    chk("midreset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    $display("midreset: scan aborted, rsp cycles seen=%0d", rsp_seen);

    // Repeated IR: the second load may be skipped when the IR cache is built in.
    do_scan("ir_first", 2'b10, 38'h05_A5A5_5A5A, 38'h3A_0F0F_F0F0, 0, 38'h3A_0F0F_F0F0,
            LAT_FULL, 2 * TD);
    do_scan("ir_repeat", 2'b10, 38'h22_1111_EEEE, 38'h0C_3333_CCCC, 0, 38'h0C_3333_CCCC,
            LAT_CACHED, UIR_CACHED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
